// File: rtl/fcu_pwm_pkg.sv
// rtl/fcu_pwm_pkg.sv - shared constants, state encoding and clamp helpers for the PWM pulse generator
//
// Purpose: timing defaults, FSM state encoding and command clamp helpers
//          shared by pwm_pulse_gen and pwm_period_timer.
// Ports:   none (package).

package fcu_pwm_pkg;

    // 50 MHz clock: cycles per microsecond
    localparam logic [5:0]  US_CYC          = 6'd50;

    // Default timing (2.5 ms period, 10 ms settle, 1000..2000 us, 0.5 s arming)
    localparam logic [16:0] PERIOD_DEF      = 17'd124_999;
    localparam logic [19:0] T_INIT_DEF      = 20'd499_999;
    localparam logic [10:0] MIN_US_DEF      = 11'd1000;
    localparam logic [10:0] MAX_US_DEF      = 11'd2000;
    localparam logic [7:0]  ARM_PERIODS_DEF = 8'd200;

    // State encoding
    localparam logic [1:0]  INIT = 2'd0;
    localparam logic [1:0]  ARM  = 2'd1;
    localparam logic [1:0]  RUN  = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT = INIT,
        ST_ARM  = ARM,
        ST_RUN  = RUN
    } pwm_state_t;

    function automatic logic [10:0] clamp_us(input logic [10:0] us,
                                             input logic [10:0] lo,
                                             input logic [10:0] hi);
        if (us < lo)
            return lo;
        else if (us > hi)
            return hi;
        else
            return us;
    endfunction

    function automatic logic out_of_range(input logic [10:0] us,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
        return (us < lo) || (us > hi);
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// rtl/pwm_period_timer.sv - free-running PWM period counter with boundary flag and start strobe
//
// Purpose: counts 0..PERIOD and wraps while enabled; held at 0 while disabled.
// Ports:
//   CLK           in   1   system clock
//   RSTn          in   1   asynchronous reset, active-low
//   en            in   1   count enable (high once the settle window is over)
//   cnt           out  17  current period counter value
//   boundary      out  1   last cycle of the period (cnt==PERIOD while enabled)
//   period_start  out  1   registered strobe, high one cycle after cnt reads 0;
//                          it coincides with the first high cycle of the pulse

import fcu_pwm_pkg::*;

module pwm_period_timer #(
    parameter logic [16:0] PERIOD = PERIOD_DEF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        en,
    output logic [16:0] cnt,
    output logic        boundary,
    output logic        period_start
);

    assign boundary = en && (cnt == PERIOD);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt          <= 17'd0;
            period_start <= 1'b0;
        end else if (!en) begin
            cnt          <= 17'd0;
            period_start <= 1'b0;
        end else begin
            cnt          <= boundary ? 17'd0 : cnt + 17'd1;
            period_start <= (cnt == 17'd0);
        end
    end

endmodule

// File: rtl/pwm_pulse_gen.sv
// rtl/pwm_pulse_gen.sv - servo/ESC pulse generator with settle, arming and period-aligned width updates
//
// Purpose: fixed-period active-high pulse whose width is commanded in us.
//          INIT holds the output low for the settle window, ARM emits MIN_US
//          pulses for ARM_PERIODS periods, RUN follows commands. Widths only
//          change at period boundaries so a pulse is never cut or stretched.
// Ports:
//   CLK           in   1   system clock
//   RSTn          in   1   asynchronous reset, active-low
//   Arm           in   1   level; 1 allows RUN, 0 forces MIN_US output
//   Cmd_Valid     in   1   command strobe
//   Cmd_Us        in   11  commanded pulse width, us
//   Cmd_Rdy       out  1   commands accepted (ARM and RUN)
//   PWM_Out       out  1   registered pulse output
//   Period_Start  out  1   one-cycle period strobe
//   Clamped       out  1   last accepted command was out of [MIN_US,MAX_US]
//   Init_Rdy      out  1   settle window elapsed; held until reset

import fcu_pwm_pkg::*;

module pwm_pulse_gen #(
    parameter logic [16:0] PERIOD      = PERIOD_DEF,
    parameter logic [19:0] T_INIT      = T_INIT_DEF,
    parameter logic [10:0] MIN_US      = MIN_US_DEF,
    parameter logic [10:0] MAX_US      = MAX_US_DEF,
    parameter logic [7:0]  ARM_PERIODS = ARM_PERIODS_DEF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Arm,
    input  logic        Cmd_Valid,
    input  logic [10:0] Cmd_Us,
    output logic        Cmd_Rdy,
    output logic        PWM_Out,
    output logic        Period_Start,
    output logic        Clamped,
    output logic        Init_Rdy
);

    localparam logic [7:0]  ARM_LAST = ARM_PERIODS - 8'd1;
    localparam logic [16:0] MIN_W    = {6'd0, MIN_US} * {11'd0, US_CYC};

    pwm_state_t  state;
    logic [19:0] settle_cnt;
    logic [7:0]  arm_cnt;
    logic [10:0] shadow_us;
    logic [10:0] active_us;
    logic [10:0] active_next;
    logic [16:0] width_cyc;
    logic [16:0] cnt;
    logic        boundary;
    logic        cmd_acc;

    pwm_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .en           (state != ST_INIT),
        .cnt          (cnt),
        .boundary     (boundary),
        .period_start (Period_Start)
    );

    assign Cmd_Rdy = (state != ST_INIT);
    assign cmd_acc = Cmd_Valid && Cmd_Rdy;

    // Width for the period that starts after this boundary. It reads the
    // registered shadow, so a command accepted in the boundary cycle itself
    // only lands one period later.
    always_comb begin
        active_next = active_us;
        if (boundary) begin
            case (state)
                ST_ARM:  active_next = (Arm && (arm_cnt == ARM_LAST)) ? shadow_us : MIN_US;
                ST_RUN:  active_next = Arm ? shadow_us : MIN_US;
                default: active_next = MIN_US;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_INIT;
            settle_cnt <= 20'd0;
            arm_cnt    <= 8'd0;
            shadow_us  <= MIN_US;
            active_us  <= MIN_US;
            width_cyc  <= MIN_W;
            PWM_Out    <= 1'b0;
            Clamped    <= 1'b0;
            Init_Rdy   <= 1'b0;
        end else begin
            if (cmd_acc) begin
                shadow_us <= clamp_us(Cmd_Us, MIN_US, MAX_US);
                Clamped   <= out_of_range(Cmd_Us, MIN_US, MAX_US);
            end

            active_us <= active_next;
            if (boundary)
                width_cyc <= {6'd0, active_next} * {11'd0, US_CYC};

            // Registered compare: the pulse rises the cycle after cnt wraps
            // and stays high for exactly width_cyc cycles.
            PWM_Out <= (state != ST_INIT) && (cnt < width_cyc);

            case (state)
                ST_INIT: begin
                    if (settle_cnt == T_INIT) begin
                        state    <= ST_ARM;
                        Init_Rdy <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 20'd1;
                    end
                end
                ST_ARM: begin
                    if (boundary) begin
                        if (!Arm) begin
                            arm_cnt <= 8'd0;
                        end else if (arm_cnt == ARM_LAST) begin
                            arm_cnt <= 8'd0;
                            state   <= ST_RUN;
                        end else begin
                            arm_cnt <= arm_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (boundary && !Arm) begin
                        arm_cnt <= 8'd0;
                        state   <= ST_ARM;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// tb/tb_pwm_pulse_gen.sv - scoreboard bench for pwm_pulse_gen

import fcu_pwm_pkg::*;

module tb_pwm_pulse_gen;

    localparam int PERIOD_TB = 999;
    localparam int MIN_TB    = 10;
    localparam int MAX_TB    = 19;

    logic        CLK;
    logic        RSTn;
    logic        Arm;
    logic        Cmd_Valid;
    logic [10:0] Cmd_Us;
    logic        Cmd_Rdy;
    logic        PWM_Out;
    logic        Period_Start;
    logic        Clamped;
    logic        Init_Rdy;

    int total = 0;
    int bad   = 0;
    int sb[$];
    int mon_hcnt = 0;

    pwm_pulse_gen #(
        .PERIOD      (17'd999),
        .T_INIT      (20'd99),
        .MIN_US      (11'd10),
        .MAX_US      (11'd19),
        .ARM_PERIODS (8'd3)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Arm          (Arm),
        .Cmd_Valid    (Cmd_Valid),
        .Cmd_Us       (Cmd_Us),
        .Cmd_Rdy      (Cmd_Rdy),
        .PWM_Out      (PWM_Out),
        .Period_Start (Period_Start),
        .Clamped      (Clamped),
        .Init_Rdy     (Init_Rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: measures each high run and compares with the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                mon_hcnt = 0;
            end else if (PWM_Out) begin
                mon_hcnt++;
            end else if (mon_hcnt != 0) begin
                if (sb.size() == 0)
                    chk("sb_extra_pulse", mon_hcnt, -1);
                else
                    chk("pulse_w", mon_hcnt, sb.pop_front());
                mon_hcnt = 0;
            end
        end
    end

    task automatic wait_ps(input int exp_w);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!Period_Start && n < 1500);
        if (!Period_Start)
            chk("ps_timeout", n, -1);
        sb.push_back(exp_w);
    endtask

    task automatic send_cmd(input int us);
        @(negedge CLK);
        Cmd_Valid = 1'b1;
        Cmd_Us    = 11'(us);
        @(negedge CLK);
        Cmd_Valid = 1'b0;
    endtask

    // Assumes RSTn is low on entry.
    task automatic init_seq();
        int quiet_bad;
        quiet_bad = 0;
        repeat (3) @(negedge CLK);
        chk("rst_pwm", PWM_Out, 0);
        chk("rst_ps", Period_Start, 0);
        chk("rst_cmd_rdy", Cmd_Rdy, 0);
        chk("rst_clamped", Clamped, 0);
        chk("rst_init_rdy", Init_Rdy, 0);
        RSTn = 1'b1;
        for (int i = 1; i <= 99; i++) begin
            @(negedge CLK);
            if (PWM_Out || Cmd_Rdy || Init_Rdy || Period_Start)
                quiet_bad++;
        end
        chk("init_quiet", quiet_bad, 0);
        @(negedge CLK);
        chk("init_rdy_100", Init_Rdy, 1);
        chk("ps_not_yet", Period_Start, 0);
        chk("cmd_rdy_arm", Cmd_Rdy, 1);
        @(negedge CLK);
        chk("first_ps", Period_Start, 1);
        sb.push_back(MIN_TB * 50);
    endtask

    initial begin
        int n;
        if (MAX_TB * int'(US_CYC) > PERIOD_TB) begin
            $display("FAIL param_legal max_width=%0d period=%0d", MAX_TB * int'(US_CYC), PERIOD_TB);
            $fatal(1);
        end
        RSTn      = 1'b0;
        Arm       = 1'b1;
        Cmd_Valid = 1'b0;
        Cmd_Us    = 11'd0;

        init_seq();                          // p0 ARM
        wait_ps(500);                        // p1 ARM
        wait_ps(500);                        // p2 ARM
        wait_ps(500);                        // p3 RUN, shadow = MIN
        repeat (100) @(negedge CLK);
        send_cmd(15);
        chk("clamped_15", Clamped, 0);
        wait_ps(750);                        // p4
        repeat (100) @(negedge CLK);
        send_cmd(5);
        chk("clamped_5", Clamped, 1);
        wait_ps(500);                        // p5
        repeat (100) @(negedge CLK);
        send_cmd(40);
        chk("clamped_40", Clamped, 1);
        wait_ps(950);                        // p6
        repeat (100) @(negedge CLK);
        send_cmd(12);
        chk("clamped_12", Clamped, 0);
        wait_ps(600);                        // p7
        repeat (100) @(negedge CLK);
        send_cmd(18);
        send_cmd(14);
        wait_ps(700);                        // p8: last command wins

        // Period_Start cycle reads cnt=1; 998 cycles later is the boundary cycle.
        repeat (998) @(negedge CLK);
        Cmd_Valid = 1'b1;
        Cmd_Us    = 11'd16;
        @(negedge CLK);
        Cmd_Valid = 1'b0;
        wait_ps(700);                        // p9 old width
        wait_ps(800);                        // p10 new width
        repeat (100) @(negedge CLK);
        Arm = 1'b0;
        wait_ps(500);                        // p11 disarmed
        wait_ps(500);                        // p12
        repeat (100) @(negedge CLK);
        Arm = 1'b1;
        wait_ps(500);                        // p13 ARM
        repeat (100) @(negedge CLK);
        send_cmd(40);
        chk("clamped_arm", Clamped, 1);
        wait_ps(500);                        // p14 ARM
        wait_ps(950);                        // p15 RUN with command from ARM
        repeat (100) @(negedge CLK);
        chk("pre_rst_pwm", PWM_Out, 1);

        @(negedge CLK);
        #2;
        sb.delete();
        RSTn = 1'b0;
        #1;
        chk("async_rst_pwm", PWM_Out, 0);
        chk("async_rst_init_rdy", Init_Rdy, 0);

        init_seq();                          // p0' ARM
        wait_ps(500);
        wait_ps(500);
        wait_ps(500);                        // p3' RUN, shadow reset to MIN

        n = 0;
        while (sb.size() != 0 && n < 1500) begin
            @(negedge CLK);
            n++;
        end
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
